// File: rtl/bram_unaligned_banked.sv
// bram_unaligned_banked
//   Byte-addressed block RAM with one read port and one write port. Both ports
//   accept unaligned accesses of 1, 2, 4 ... bytes (size given as log2). Storage
//   is split into WIDTH_BYTES byte-wide banks. An access that crosses a row
//   boundary, or the top of memory, completes in one cycle because each bank
//   gets its own row index. Data is rotated by the byte offset on the way in
//   and on the way out.
//
// Ports
//   clock          rising-edge clock
//   rst_n          asynchronous active-low reset (memory contents are kept)
//   rd_en          read request
//   raddr, rsize   read byte address (any alignment), log2 of the byte count
//   rdata          read data: byte k = mem[raddr+k]; bytes past the size are 0
//   rvalid         one-cycle pulse per read; rdata holds while it is low
//   rd_err         pulses with rvalid when rsize is too large (rdata is then 0)
//   wr_en          write request
//   waddr, wsize   write byte address (any alignment), log2 of the byte count
//   wdata          write data: byte k goes to mem[waddr+k]
//   wr_err         pulses the cycle after a write with a size that is too large
//
// Read latency is 1 cycle (OUT_REG=0) or 2 cycles (OUT_REG=1). When a read
// and a write on the same edge touch the same byte, RDW_MODE=1 returns the
// new byte and RDW_MODE=0 returns the old byte.
module bram_unaligned_banked #(
  parameter int WIDTH_BYTES = 4,
  parameter int DEPTH_WORDS = 512,
  parameter int ADDR_W      = 11,
  parameter int OUT_REG     = 0,
  parameter int RDW_MODE    = 1
) (
  input  logic                     clock,
  input  logic                     rst_n,
  input  logic                     rd_en,
  input  logic [ADDR_W-1:0]        raddr,
  input  logic [1:0]               rsize,
  output logic [8*WIDTH_BYTES-1:0] rdata,
  output logic                     rvalid,
  output logic                     rd_err,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        waddr,
  input  logic [1:0]               wsize,
  input  logic [8*WIDTH_BYTES-1:0] wdata,
  output logic                     wr_err
);

  localparam int OFF_W = $clog2(WIDTH_BYTES);
  localparam int ROW_W = ADDR_W - OFF_W;
  localparam int DW    = 8 * WIDTH_BYTES;

  // Address split: low bits select the starting bank, high bits the row.
  logic [OFF_W-1:0] roff, woff;
  logic [ROW_W-1:0] rrow, wrow;
  logic             rlegal, wlegal;
  logic             wr_go;

  assign roff = raddr[OFF_W-1:0];
  assign woff = waddr[OFF_W-1:0];
  assign rrow = raddr[ADDR_W-1:OFF_W];
  assign wrow = waddr[ADDR_W-1:OFF_W];

  // A size is legal when 1<<size fits in one row.
  assign rlegal = ({30'b0, rsize} <= 32'(OFF_W));
  assign wlegal = ({30'b0, wsize} <= 32'(OFF_W));

  // Writes are blocked while reset is held.
  assign wr_go = wr_en & rst_n & wlegal;

  logic [DW-1:0]          bank_vec;    // per-bank read byte, bank order
  logic [WIDTH_BYTES-1:0] rmask_next;  // which output bytes the read returns

  for (genvar gi = 0; gi < WIDTH_BYTES; gi++) begin : g_bank
    logic [7:0]       mem_arr [DEPTH_WORDS];
    logic [OFF_W-1:0] wk;             // position of this bank's byte in the write
    logic [ROW_W-1:0] wrow_b, rrow_b;
    logic             we_b;
    logic [7:0]       wbyte_b;
    logic [7:0]       rd_reg;
    logic             byp_reg;
    logic [7:0]       byp_data_reg;

    // Banks below the starting offset hold the bytes that spilled into the
    // next row; the row counter wraps naturally at the top of memory.
    assign wk      = OFF_W'(gi) - woff;
    assign wrow_b  = wrow + ROW_W'(OFF_W'(gi) < woff);
    assign rrow_b  = rrow + ROW_W'(OFF_W'(gi) < roff);
    assign we_b    = wr_go && ((wk >> wsize) == '0);
    assign wbyte_b = wdata[{wk, 3'b000} +: 8];

    always_ff @(posedge clock) begin
      if (we_b) begin
        mem_arr[wrow_b] <= wbyte_b;
      end
      if (rd_en) begin
        rd_reg <= mem_arr[rrow_b];
      end
    end

    // Same-edge write to the very byte being read: remember the new byte so
    // the output can return it instead of the stale array read.
    always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
        byp_reg      <= 1'b0;
        byp_data_reg <= 8'h00;
      end else if (rd_en) begin
        byp_reg      <= (RDW_MODE != 0) && we_b && (wrow_b == rrow_b);
        byp_data_reg <= wbyte_b;
      end
    end

    assign bank_vec[8*gi +: 8] = byp_reg ? byp_data_reg : rd_reg;
    assign rmask_next[gi]      = rlegal && ((OFF_W'(gi) >> rsize) == '0);
  end

  // First read stage: control registers that travel with the array read.
  logic                   valid1_reg;
  logic                   err1_reg;
  logic [OFF_W-1:0]       roff_reg;
  logic [WIDTH_BYTES-1:0] rmask_reg;
  logic                   wr_err_reg;
  logic [DW-1:0]          rdata1;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      valid1_reg <= 1'b0;
      err1_reg   <= 1'b0;
      roff_reg   <= '0;
      rmask_reg  <= '0;
      wr_err_reg <= 1'b0;
    end else begin
      valid1_reg <= rd_en;
      err1_reg   <= rd_en && !rlegal;
      wr_err_reg <= wr_en && !wlegal;
      // Only updated on a read, so rdata holds between reads. A cleared mask
      // also forces rdata to 0 after reset.
      if (rd_en) begin
        roff_reg  <= roff;
        rmask_reg <= rmask_next;
      end
    end
  end

  // Rotate bank order back into access order and zero unrequested bytes.
  for (genvar gi = 0; gi < WIDTH_BYTES; gi++) begin : g_rot
    logic [OFF_W-1:0] src;
    assign src = roff_reg + OFF_W'(gi);
    assign rdata1[8*gi +: 8] = rmask_reg[gi] ? bank_vec[{src, 3'b000} +: 8] : 8'h00;
  end

  assign wr_err = wr_err_reg;

  if (OUT_REG != 0) begin : g_oreg
    logic [DW-1:0] rdata_reg;
    logic          rvalid_reg;
    logic          rd_err_reg;

    always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
        rdata_reg  <= '0;
        rvalid_reg <= 1'b0;
        rd_err_reg <= 1'b0;
      end else begin
        rvalid_reg <= valid1_reg;
        rd_err_reg <= err1_reg;
        if (valid1_reg) begin
          rdata_reg <= rdata1;
        end
      end
    end

    assign rdata  = rdata_reg;
    assign rvalid = rvalid_reg;
    assign rd_err = rd_err_reg;
  end else begin : g_noreg
    assign rdata  = rdata1;
    assign rvalid = valid1_reg;
    assign rd_err = err1_reg;
  end

endmodule

// File: tb/tb_bram_unaligned_banked.sv
// Bench for bram_unaligned_banked. Two instances share all stimulus:
//   dut   : defaults (OUT_REG=0, RDW_MODE=1) -> latency 1, new data on collision
//   dut_b : OUT_REG=1, RDW_MODE=0            -> latency 2, old data on collision
// Expected values come from a byte-array model of memory.
module tb_bram_unaligned_banked;

  localparam int WB = 4;
  localparam int MEM_BYTES = 2048;

  logic        clock = 1'b0;
  logic        rst_n = 1'b0;
  logic        rd_en = 1'b0;
  logic [10:0] raddr = '0;
  logic [1:0]  rsize = '0;
  logic        wr_en = 1'b0;
  logic [10:0] waddr = '0;
  logic [1:0]  wsize = '0;
  logic [31:0] wdata = '0;

  logic [31:0] rdata, rdata_b;
  logic        rvalid, rvalid_b, rd_err, rd_err_b, wr_err, wr_err_b;

  int total = 0;
  int bad = 0;

  logic [7:0] mem_m [MEM_BYTES];

  always #5 clock = ~clock;

  bram_unaligned_banked dut (
    .clock(clock), .rst_n(rst_n),
    .rd_en(rd_en), .raddr(raddr), .rsize(rsize),
    .rdata(rdata), .rvalid(rvalid), .rd_err(rd_err),
    .wr_en(wr_en), .waddr(waddr), .wsize(wsize), .wdata(wdata),
    .wr_err(wr_err)
  );

  bram_unaligned_banked #(.OUT_REG(1), .RDW_MODE(0)) dut_b (
    .clock(clock), .rst_n(rst_n),
    .rd_en(rd_en), .raddr(raddr), .rsize(rsize),
    .rdata(rdata_b), .rvalid(rvalid_b), .rd_err(rd_err_b),
    .wr_en(wr_en), .waddr(waddr), .wsize(wsize), .wdata(wdata),
    .wr_err(wr_err_b)
  );

  // ---------------- reference model ----------------
  function automatic logic [31:0] model_rd(input logic [10:0] a, input logic [1:0] s);
    logic [31:0] v;
    int n;
    v = '0;
    n = 1 << s;
    if (n > WB) return '0;
    for (int k = 0; k < n; k++) v[8*k +: 8] = mem_m[(int'(a) + k) % MEM_BYTES];
    return v;
  endfunction

  task automatic model_wr(input logic [10:0] a, input logic [1:0] s, input logic [31:0] d);
    int n;
    n = 1 << s;
    if (n > WB) return;
    for (int k = 0; k < n; k++) mem_m[(int'(a) + k) % MEM_BYTES] = d[8*k +: 8];
  endtask

  // ---------------- drivers (called at posedge+1) ----------------
  // One edge of stimulus. exp_new/exp_old are the read result with the
  // same-edge write applied / not applied.
  task automatic op(input bit rd, input logic [10:0] ra, input logic [1:0] rs,
                    input bit wr, input logic [10:0] wa, input logic [1:0] ws,
                    input logic [31:0] wd,
                    output logic [31:0] exp_new, output logic [31:0] exp_old);
    exp_old = model_rd(ra, rs);
    if (wr) model_wr(wa, ws, wd);
    exp_new = model_rd(ra, rs);
    rd_en = rd; raddr = ra; rsize = rs;
    wr_en = wr; waddr = wa; wsize = ws; wdata = wd;
    @(posedge clock);
    #1;
    rd_en = 1'b0;
    wr_en = 1'b0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (3) @(posedge clock);
    #1;
    total++;
    if ({rdata, rvalid, rd_err, wr_err} !== 35'd0) begin
      bad++; $display("FAIL reset_hold dut got=%h/%b/%b/%b want=0/0/0/0", rdata, rvalid, rd_err, wr_err);
    end
    total++;
    if ({rdata_b, rvalid_b, rd_err_b, wr_err_b} !== 35'd0) begin
      bad++; $display("FAIL reset_hold dut_b got=%h/%b/%b/%b want=0/0/0/0", rdata_b, rvalid_b, rd_err_b, wr_err_b);
    end
    #3 rst_n = 1'b1;
    tick();
    total++;
    if ({rdata, rvalid, rdata_b, rvalid_b} !== 66'd0) begin
      bad++; $display("FAIL reset_release got=%h/%b %h/%b want=0/0 0/0", rdata, rvalid, rdata_b, rvalid_b);
    end
  endtask

  task automatic init_mem();
    logic [31:0] en, eo;
    for (int a = 0; a < MEM_BYTES / WB; a++)
      op(1'b0, 11'd0, 2'd0, 1'b1, 11'(a * WB), 2'd2, 32'd0, en, eo);
  endtask

  task automatic test_basic();
    logic [10:0] a_t [4] = '{11'h004, 11'h000, 11'h003, 11'h005};
    logic [1:0]  s_t [4] = '{2'd2, 2'd2, 2'd1, 2'd0};
    logic [31:0] e_t [4] = '{32'h00123456, 32'h78000000, 32'h00005678, 32'h00000034};
    logic [31:0] en, eo;
    op(1'b0, '0, '0, 1'b1, 11'h000, 2'd2, 32'h0, en, eo);
    op(1'b0, '0, '0, 1'b1, 11'h004, 2'd2, 32'h0, en, eo);
    op(1'b0, '0, '0, 1'b1, 11'h003, 2'd2, 32'h12345678, en, eo);
    for (int i = 0; i < 4; i++) begin
      op(1'b1, a_t[i], s_t[i], 1'b0, '0, '0, '0, en, eo);
      total++;
      if ({rvalid, rd_err, rdata} !== {2'b10, e_t[i]}) begin
        bad++; $display("FAIL basic_rd%0d got=%b/%b/%h want=1/0/%h", i, rvalid, rd_err, rdata, e_t[i]);
      end
      tick();
      total++;
      if ({rvalid_b, rd_err_b, rdata_b} !== {2'b10, e_t[i]}) begin
        bad++; $display("FAIL basic_rd%0d_b got=%b/%b/%h want=1/0/%h", i, rvalid_b, rd_err_b, rdata_b, e_t[i]);
      end
      total++;
      if ({rvalid, rdata} !== {1'b0, e_t[i]}) begin
        bad++; $display("FAIL basic_hold%0d got=%b/%h want=0/%h", i, rvalid, rdata, e_t[i]);
      end
    end
  endtask

  task automatic test_wrap();
    logic [10:0] a_t [3] = '{11'h7FF, 11'h000, 11'h7FE};
    logic [1:0]  s_t [3] = '{2'd0, 2'd1, 2'd2};
    logic [31:0] e_t [3] = '{32'h000000CC, 32'h0000AABB, 32'hAABBCCDD};
    logic [31:0] en, eo;
    op(1'b0, '0, '0, 1'b1, 11'h7FE, 2'd2, 32'hAABBCCDD, en, eo);
    for (int i = 0; i < 3; i++) begin
      op(1'b1, a_t[i], s_t[i], 1'b0, '0, '0, '0, en, eo);
      total++;
      if ({rvalid, rdata} !== {1'b1, e_t[i]}) begin
        bad++; $display("FAIL wrap_rd%0d got=%b/%h want=1/%h", i, rvalid, rdata, e_t[i]);
      end
      tick();
      total++;
      if ({rvalid_b, rdata_b} !== {1'b1, e_t[i]}) begin
        bad++; $display("FAIL wrap_rd%0d_b got=%b/%h want=1/%h", i, rvalid_b, rdata_b, e_t[i]);
      end
    end
  endtask

  task automatic test_rdw();
    logic [31:0] en, eo;
    op(1'b0, '0, '0, 1'b1, 11'h006, 2'd1, 32'h0000FFEE, en, eo);
    op(1'b0, '0, '0, 1'b1, 11'h008, 2'd1, 32'h00005A5A, en, eo);
    op(1'b1, 11'h006, 2'd2, 1'b1, 11'h008, 2'd2, 32'h11223344, en, eo);
    total++;
    if ({rvalid, rdata} !== {1'b1, 32'h3344FFEE}) begin
      bad++; $display("FAIL rdw_new got=%b/%h want=1/3344ffee", rvalid, rdata);
    end
    tick();
    total++;
    if ({rvalid_b, rdata_b} !== {1'b1, 32'h5A5AFFEE}) begin
      bad++; $display("FAIL rdw_old got=%b/%h want=1/5a5affee", rvalid_b, rdata_b);
    end
    op(1'b1, 11'h008, 2'd2, 1'b0, '0, '0, '0, en, eo);
    total++;
    if (rdata !== 32'h11223344) begin
      bad++; $display("FAIL rdw_stored got=%h want=11223344", rdata);
    end
  endtask

  task automatic test_illegal();
    logic [31:0] en, eo;
    op(1'b0, '0, '0, 1'b1, 11'h000, 2'd3, 32'h99999999, en, eo);
    total++;
    if ({wr_err, wr_err_b} !== 2'b11) begin
      bad++; $display("FAIL wr_err_pulse got=%b/%b want=1/1", wr_err, wr_err_b);
    end
    tick();
    total++;
    if ({wr_err, wr_err_b} !== 2'b00) begin
      bad++; $display("FAIL wr_err_clear got=%b/%b want=0/0", wr_err, wr_err_b);
    end
    op(1'b1, 11'h000, 2'd2, 1'b0, '0, '0, '0, en, eo);
    total++;
    if (rdata !== 32'h7800AABB) begin
      bad++; $display("FAIL illegal_wr_nochange got=%h want=7800aabb", rdata);
    end
    op(1'b1, 11'h001, 2'd3, 1'b0, '0, '0, '0, en, eo);
    total++;
    if ({rvalid, rd_err, rdata} !== {2'b11, 32'h0}) begin
      bad++; $display("FAIL rd_err got=%b/%b/%h want=1/1/0", rvalid, rd_err, rdata);
    end
    tick();
    total++;
    if ({rvalid_b, rd_err_b, rdata_b} !== {2'b11, 32'h0}) begin
      bad++; $display("FAIL rd_err_b got=%b/%b/%h want=1/1/0", rvalid_b, rd_err_b, rdata_b);
    end
    total++;
    if ({rvalid, rd_err} !== 2'b00) begin
      bad++; $display("FAIL rd_err_clear got=%b/%b want=0/0", rvalid, rd_err);
    end
  endtask

  task automatic test_pipeline();
    logic [31:0] exp_q [3];
    logic [31:0] en, eo;
    for (int i = 0; i < 3; i++) begin
      op(1'b1, 11'(4 * i), 2'd2, 1'b0, '0, '0, '0, en, eo);
      exp_q[i] = en;
      total++;
      if ({rvalid, rdata} !== {1'b1, en}) begin
        bad++; $display("FAIL pipe_a%0d got=%b/%h want=1/%h", i, rvalid, rdata, en);
      end
      if (i == 0) begin
        total++;
        if (rvalid_b !== 1'b0) begin
          bad++; $display("FAIL pipe_b_early got=%b want=0", rvalid_b);
        end
      end else begin
        total++;
        if ({rvalid_b, rdata_b} !== {1'b1, exp_q[i-1]}) begin
          bad++; $display("FAIL pipe_b%0d got=%b/%h want=1/%h", i - 1, rvalid_b, rdata_b, exp_q[i-1]);
        end
      end
    end
    tick();
    total++;
    if ({rvalid_b, rdata_b, rvalid} !== {1'b1, exp_q[2], 1'b0}) begin
      bad++; $display("FAIL pipe_b2 got=%b/%h a_valid=%b want=1/%h a_valid=0", rvalid_b, rdata_b, rvalid, exp_q[2]);
    end
    tick();
    total++;
    if ({rvalid_b, rdata_b} !== {1'b0, exp_q[2]}) begin
      bad++; $display("FAIL pipe_b_end got=%b/%h want=0/%h", rvalid_b, rdata_b, exp_q[2]);
    end
  endtask

  task automatic test_random();
    logic [31:0] en, eo, wd, pend_d, last_a, last_b;
    logic [10:0] ra, wa;
    logic [1:0]  rs, ws;
    bit rd, wr, pend_v, pend_e, has_a, has_b;
    pend_v = 0; pend_e = 0; has_a = 0; has_b = 0;
    pend_d = '0; last_a = '0; last_b = '0;
    for (int i = 0; i < 600; i++) begin
      rd = ($urandom_range(0, 3) != 0);
      wr = ($urandom_range(0, 2) != 0);
      ra = 11'($urandom_range(0, MEM_BYTES - 1));
      wa = ($urandom_range(0, 1) == 1) ? 11'(ra + 11'($urandom_range(0, 6)) - 11'd3)
                                       : 11'($urandom_range(0, MEM_BYTES - 1));
      rs = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      ws = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      wd = $urandom();
      op(rd, ra, rs, wr, wa, ws, wd, en, eo);
      total++;
      if ({rvalid, rd_err} !== {rd, rd && (rs == 2'd3)}) begin
        bad++; $display("FAIL rand%0d_a_flags got=%b/%b want=%b/%b", i, rvalid, rd_err, rd, rd && (rs == 2'd3));
      end
      if (rd || has_a) begin
        total++;
        if (rdata !== (rd ? en : last_a)) begin
          bad++; $display("FAIL rand%0d_a_data ra=%h rs=%0d got=%h want=%h", i, ra, rs, rdata, rd ? en : last_a);
        end
      end
      total++;
      if ({rvalid_b, rd_err_b} !== {pend_v, pend_e}) begin
        bad++; $display("FAIL rand%0d_b_flags got=%b/%b want=%b/%b", i, rvalid_b, rd_err_b, pend_v, pend_e);
      end
      if (pend_v || has_b) begin
        total++;
        if (rdata_b !== (pend_v ? pend_d : last_b)) begin
          bad++; $display("FAIL rand%0d_b_data got=%h want=%h", i, rdata_b, pend_v ? pend_d : last_b);
        end
      end
      total++;
      if ({wr_err, wr_err_b} !== {2{wr && (ws == 2'd3)}}) begin
        bad++; $display("FAIL rand%0d_wr_err got=%b/%b want=%b", i, wr_err, wr_err_b, wr && (ws == 2'd3));
      end
      if (pend_v) begin last_b = pend_d; has_b = 1; end
      if (rd) begin last_a = en; has_a = 1; end
      pend_v = rd;
      pend_e = rd && (rs == 2'd3);
      pend_d = eo;
    end
    tick();
    tick();
  endtask

  task automatic test_reset_inflight();
    logic [31:0] en, eo;
    op(1'b0, '0, '0, 1'b1, 11'h040, 2'd2, 32'hCAFEF00D, en, eo);
    // read accepted at this edge, then a short reset pulse before the next one
    rd_en = 1'b1; raddr = 11'h040; rsize = 2'd2;
    @(posedge clock);
    #1 rd_en = 1'b0;
    #1 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    tick();
    total++;
    if ({rvalid, rdata, rvalid_b, rdata_b} !== 66'd0) begin
      bad++; $display("FAIL inflight_drop got=%b/%h %b/%h want=0/0 0/0", rvalid, rdata, rvalid_b, rdata_b);
    end
    tick();
    total++;
    if ({rvalid_b, rdata_b} !== 33'd0) begin
      bad++; $display("FAIL inflight_drop_b got=%b/%h want=0/0", rvalid_b, rdata_b);
    end
    // a write presented while reset is held must be ignored (model untouched)
    wr_en = 1'b1; waddr = 11'h100; wsize = 2'd2; wdata = 32'hDEADBEEF;
    rst_n = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #1 wr_en = 1'b0;
    #3 rst_n = 1'b1;
    tick();
    op(1'b1, 11'h100, 2'd2, 1'b0, '0, '0, '0, en, eo);
    total++;
    if (rdata !== en) begin
      bad++; $display("FAIL wr_in_reset got=%h want=%h", rdata, en);
    end
    op(1'b1, 11'h040, 2'd2, 1'b0, '0, '0, '0, en, eo);
    total++;
    if ({rvalid, rdata} !== {1'b1, 32'hCAFEF00D}) begin
      bad++; $display("FAIL mem_kept got=%b/%h want=1/cafef00d", rvalid, rdata);
    end
    tick();
    total++;
    if ({rvalid_b, rdata_b} !== {1'b1, 32'hCAFEF00D}) begin
      bad++; $display("FAIL mem_kept_b got=%b/%h want=1/cafef00d", rvalid_b, rdata_b);
    end
  endtask

  initial begin
    for (int i = 0; i < MEM_BYTES; i++) mem_m[i] = 8'h00;
    rd_en = 1'b0; wr_en = 1'b0;
    #1;
    test_reset();
    init_mem();
    test_basic();
    test_wrap();
    test_rdw();
    test_illegal();
    test_pipeline();
    test_random();
    test_reset_inflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
